// File: rtl/registrador_anel_parametrizado_if.sv
// Control and status bundle for the parametrised ring/Johnson shift register.
interface registrador_anel_parametrizado_if #(
  parameter int WIDTH = 5
);
  localparam int PW = $clog2(2 * WIDTH);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir;
  logic             mode;
  logic [WIDTH-1:0] out;
  logic [PW-1:0]    pos;
  logic             wrap;
  logic             illegal;

  modport master (
    output en, load, load_val, dir, mode,
    input  out, pos, wrap, illegal
  );

  modport slave (
    input  en, load, load_val, dir, mode,
    output out, pos, wrap, illegal
  );
endinterface

// File: rtl/registrador_anel_parametrizado.sv
// Ring / twisted-ring (Johnson) shift register.
// Tracks the shift position within the current period and pulses wrap at each period end.
module registrador_anel_parametrizado #(
  parameter int WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  registrador_anel_parametrizado_if.slave   rb
);
  localparam int PW = $clog2(2 * WIDTH);
  localparam logic [PW-1:0] LAST_RING  = PW'(WIDTH - 1);
  localparam logic [PW-1:0] LAST_TWIST = PW'(2 * WIDTH - 1);

  logic [WIDTH-1:0] out_q;
  logic [PW-1:0]    pos_q;
  logic             wrap_q;
  logic [WIDTH-1:0] shifted;
  logic [PW-1:0]    last_pos;
  logic [5:0]       diff_cnt;

  always_comb begin
    shifted = out_q;
    if (rb.dir)
      shifted = {out_q[WIDTH-2:0], rb.mode ? ~out_q[WIDTH-1] : out_q[WIDTH-1]};
    else
      shifted = {rb.mode ? ~out_q[0] : out_q[0], out_q[WIDTH-1:1]};
  end

  // A ">=" compare lets a twisted-to-ring switch with pos beyond the ring period wrap at once.
  assign last_pos = rb.mode ? LAST_TWIST : LAST_RING;

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q  <= '0;
      pos_q  <= '0;
      wrap_q <= 1'b0;
    end else if (rb.load) begin
      out_q  <= rb.load_val;
      pos_q  <= '0;
      wrap_q <= 1'b0;
    end else if (rb.en) begin
      out_q <= shifted;
      if (pos_q >= last_pos) begin
        pos_q  <= '0;
        wrap_q <= 1'b1;
      end else begin
        pos_q  <= pos_q + PW'(1);
        wrap_q <= 1'b0;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  always_comb begin
    diff_cnt = '0;
    for (int unsigned i = 0; i < WIDTH - 1; i++) begin
      if (out_q[i] != out_q[i+1])
        diff_cnt = diff_cnt + 6'd1;
    end
  end

  assign rb.out     = out_q;
  assign rb.pos     = pos_q;
  assign rb.wrap    = wrap_q;
  assign rb.illegal = rb.mode && (diff_cnt > 6'd1);
endmodule

// File: doc/registrador_anel_parametrizado.md
REGISTRADOR_ANEL_PARAMETRIZADO -- requirements
Module: registrador_anel_parametrizado

Interface
REQ-001 Parameter: WIDTH, default 5, register width; legal range 2..32.
REQ-002 Derived constant: PW = $clog2(2*WIDTH), width of the position counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low; sampled on the rising edge of clk.
REQ-005 en  input  1  shift enable.
REQ-006 load  input  1  parallel load strobe.
REQ-007 load_val  input  WIDTH  value written on load.
REQ-008 dir  input  1  shift direction: 0 right (toward bit 0), 1 left (toward bit WIDTH-1).
REQ-009 mode  input  1  0 pure ring, 1 twisted ring (Johnson).
REQ-010 out  output  WIDTH  register contents, registered.
REQ-011 pos  output  PW  shifts since the last load, reset or wrap; registered.
REQ-012 wrap  output  1  one-cycle pulse, registered; set after a full period completes.
REQ-013 illegal  output  1  combinational flag for an invalid Johnson code in twisted mode.

Function
REQ-014 Per-edge priority SHALL be: rst low, then load, then en, then hold.
REQ-015 Right ring shift SHALL be out <= {out[0], out[WIDTH-1:1]}.
REQ-016 Right twisted shift SHALL be out <= {~out[0], out[WIDTH-1:1]}.
REQ-017 Left ring shift SHALL be out <= {out[WIDTH-2:0], out[WIDTH-1]}.
REQ-018 Left twisted shift SHALL be out <= {out[WIDTH-2:0], ~out[WIDTH-1]}.
REQ-019 dir and mode SHALL be sampled on every shift edge and may change between any two shifts with no restart.
REQ-020 Load (load=1) SHALL set out=load_val, pos=0 and wrap=0, whatever the value of en.
REQ-021 Hold (en=0, load=0) SHALL leave out and pos unchanged and set wrap=0.
REQ-022 PERIOD SHALL be WIDTH when mode=0 and 2*WIDTH when mode=1, evaluated with the mode value on the current edge.
REQ-023 On a shift, if pos >= PERIOD-1, pos SHALL become 0 and wrap SHALL become 1; otherwise pos SHALL increment by 1 and wrap SHALL become 0.
REQ-024 The pos >= PERIOD-1 rule SHALL also cover mode switching from 1 to 0 while pos >= WIDTH: the next shift wraps pos to 0.
REQ-025 wrap SHALL be high for exactly one cycle per wrap event, including on back-to-back shifts.
REQ-026 illegal SHALL be 0 when mode=0.
REQ-027 When mode=1, illegal SHALL be 1 iff the count of adjacent-bit differences (out[i] != out[i+1], i=0..WIDTH-2) exceeds 1.
REQ-028 The block SHALL NOT self-correct illegal codes; it SHALL keep shifting them per REQ-015..018.
REQ-029 pos arithmetic SHALL be unsigned PW-bit and SHALL never exceed 2*WIDTH-1.

Reset
REQ-030 When rst=0 on a rising edge, out SHALL become all zeros, pos SHALL become 0 and wrap SHALL become 0.
REQ-031 Reset SHALL override load and en on the same edge.
REQ-032 A reset during a period SHALL abandon it, with no wrap pulse.
REQ-033 The first shift after rst returns high SHALL start from 0.
REQ-034 The reset value all-zeros SHALL be a legal Johnson code, so illegal=0 after reset in either mode.

Verification
REQ-035 Reset: WIDTH=5, drive rst=0 for 1 edge with load=1 and en=1 -> out=00000, pos=0, wrap=0, illegal=0.
REQ-036 Twisted right: mode=1, dir=0, en=1 from 00000 -> 10000,11000,11100,11110,11111,01111,00111,00011,00001,00000, with pos 1..9,0 and wrap=1 only after the 10th shift.
REQ-037 Ring left: load_val=00001, mode=0, dir=1 -> 00010,00100,01000,10000,00001, with wrap=1 only after the 5th shift.
REQ-038 Priority/hold: load=1, en=1, load_val=10101 -> out=10101, pos=0; then en=0 for 3 cycles -> out and pos unchanged, wrap=0.
REQ-039 Illegal flag: load 10100 with mode=1 -> illegal=1; switch to mode=0 -> illegal=0; load 11100 with mode=1 -> illegal=0.
REQ-040 Mode switch: mode=1, shift 7 times (pos=7), set mode=0, shift once -> pos=0 and wrap=1; then rst=0 mid-sequence -> out=00000, pos=0.
